led_matrix_scanner: RTL and testbench

Downstream display stage of the Snake Game Arcade: it takes the 36-bit 6x6 frame produced by the game renderer and drives a physical row-multiplexed LED matrix. Frames are accepted through a valid/ready handshake into a pending buffer and promoted to the display buffer only at frame boundaries, so a frame never tears. Rows are scanned one-hot, and a dark interval between rows suppresses ghosting.

---
 rtl/sga_pkg.sv | 32 +++
 rtl/led_matrix_scanner_if.sv | 25 ++
 rtl/led_matrix_scanner_scan_timer.sv | 49 ++++
 rtl/led_matrix_scanner.sv | 176 +++++++++++++++++
 tb/tb_led_matrix_scanner.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/sga_pkg.sv
// Shared Snake Game Arcade display definitions: matrix geometry, scan states
// and the frame row-slice helper used by the display stage.
package sga_pkg;

  localparam int SGA_ROWS    = 6;
  localparam int SGA_COLS    = 6;
  localparam int SGA_FRAME_W = SGA_ROWS * SGA_COLS;
  localparam int SGA_ROW_W   = 3;

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } scan_state_e;

  // Row r occupies bits r*COLS +: COLS, so row 0 is frame[5:0].
  function automatic logic [SGA_COLS-1:0] frame_row(
    input logic [SGA_FRAME_W-1:0] frame,
    input logic [SGA_ROW_W-1:0]   r
  );
    logic [SGA_COLS-1:0] slice_s;
    slice_s = {SGA_COLS{1'b0}};
    for (int i = 0; i < SGA_ROWS; i++) begin
      if (r == SGA_ROW_W'(i)) begin
        slice_s = frame[i*SGA_COLS +: SGA_COLS];
      end else begin
        slice_s = slice_s;
      end
    end
    return slice_s;
  endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Frame handshake and matrix drive bundle between the renderer side (master)
// and the LED matrix scanner (slave).
interface led_matrix_scanner_if;
  import sga_pkg::*;

  logic [SGA_FRAME_W-1:0] frame;
  logic                   frame_valid;
  logic                   frame_ready;
  logic                   blank;
  logic [SGA_ROWS-1:0]    rows;
  logic [SGA_COLS-1:0]    cols;
  logic [SGA_ROW_W-1:0]   row_index;
  logic                   frame_sync;

  modport master (
    output frame, frame_valid, blank,
    input  frame_ready, rows, cols, row_index, frame_sync
  );

  modport slave (
    input  frame, frame_valid, blank,
    output frame_ready, rows, cols, row_index, frame_sync
  );

endinterface

// File: rtl/led_matrix_scanner_scan_timer.sv
// Phase counter for the row scan: counts cycles inside the current BLANK or ON
// phase and flags its first and last cycle.
module scan_timer #(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clock,
  input  logic reset,
  input  logic is_on,
  output logic phase_done,
  output logic phase_first
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] last_s;

  // Terminal count depends on which phase the scanner is in.
  always_comb begin
    last_s = BLANK_LAST;
    if (is_on) begin
      last_s = DWELL_LAST;
    end else begin
      last_s = BLANK_LAST;
    end
  end

  assign phase_done  = (cnt_r == last_s);
  assign phase_first = (cnt_r == CNT_ZERO);

  // Restart at zero whenever the phase ends, so every phase starts clean.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= CNT_ZERO;
    end else if (phase_done) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed 6x6 LED matrix driver: double-buffered frame intake via
// valid/ready, tear-free promotion at frame end, blanked one-hot row scan.
module led_matrix_scanner
  import sga_pkg::*;
#(
  parameter int ROWS           = SGA_ROWS,
  parameter int COLS           = SGA_COLS,
  parameter int DWELL_CYCLES   = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  led_matrix_scanner_if.slave  bus
);

  localparam logic [SGA_ROW_W-1:0] LAST_ROW = SGA_ROW_W'(ROWS - 1);
  localparam logic [SGA_ROW_W-1:0] ROW_ZERO = {SGA_ROW_W{1'b0}};
  localparam logic [SGA_ROW_W-1:0] ROW_ONE  = SGA_ROW_W'(1'b1);
  localparam logic [COLS-1:0]      COLS_OFF = COL_ACTIVE_LOW ? {COLS{1'b1}} : {COLS{1'b0}};
  localparam logic [ROWS-1:0]      ROWS_OFF = {ROWS{1'b0}};

  scan_state_e            state_r;
  scan_state_e            state_next_s;
  logic [SGA_ROW_W-1:0]   row_r;
  logic [SGA_ROW_W-1:0]   row_next_s;

  logic                   phase_done_s;
  logic                   phase_first_s;
  logic                   is_on_s;
  logic                   boundary_s;
  logic                   ready_s;
  logic                   accept_s;
  logic                   lit_s;
  logic                   sync_s;

  logic [SGA_FRAME_W-1:0] pending_r;
  logic                   full_r;
  logic [SGA_FRAME_W-1:0] display_r;

  logic [SGA_COLS-1:0]    row_bits_s;
  logic [COLS-1:0]        col_drive_s;
  logic [ROWS-1:0]        row_drive_s;

  logic [ROWS-1:0]        rows_r;
  logic [COLS-1:0]        cols_r;
  logic [SGA_ROW_W-1:0]   row_index_r;
  logic                   frame_sync_r;

  scan_timer #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scan_timer (
    .clock       (clock),
    .reset       (reset),
    .is_on       (is_on_s),
    .phase_done  (phase_done_s),
    .phase_first (phase_first_s)
  );

  assign is_on_s    = (state_r == S_ON);
  // Frame boundary: final lit cycle of the last row; the display swaps here.
  assign boundary_s = is_on_s && (row_r == LAST_ROW) && phase_done_s;
  assign ready_s    = !full_r || boundary_s;
  assign accept_s   = bus.frame_valid && ready_s;
  assign sync_s     = (state_r == S_BLANK) && (row_r == ROW_ZERO) && phase_first_s;

  // Scan state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= S_BLANK;
      row_r   <= ROW_ZERO;
    end else begin
      state_r <= state_next_s;
      row_r   <= row_next_s;
    end
  end

  // Next-state logic: BLANK -> ON -> BLANK of the following row.
  always_comb begin
    state_next_s = state_r;
    row_next_s   = row_r;
    case (state_r)
      S_BLANK: begin
        if (phase_done_s) begin
          state_next_s = S_ON;
        end else begin
          state_next_s = S_BLANK;
        end
      end
      S_ON: begin
        if (phase_done_s) begin
          state_next_s = S_BLANK;
          if (row_r == LAST_ROW) begin
            row_next_s = ROW_ZERO;
          end else begin
            row_next_s = row_r + ROW_ONE;
          end
        end else begin
          state_next_s = S_ON;
        end
      end
      default: begin
        state_next_s = S_BLANK;
        row_next_s   = ROW_ZERO;
      end
    endcase
  end

  // Pending/display buffers; an accept at the boundary refills pending while
  // the old pending frame moves to display in the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_r <= {SGA_FRAME_W{1'b0}};
      full_r    <= 1'b0;
      display_r <= {SGA_FRAME_W{1'b0}};
    end else begin
      if (boundary_s && full_r) begin
        display_r <= pending_r;
      end else begin
        display_r <= display_r;
      end
      if (accept_s) begin
        pending_r <= bus.frame;
        full_r    <= 1'b1;
      end else if (boundary_s) begin
        pending_r <= pending_r;
        full_r    <= 1'b0;
      end else begin
        pending_r <= pending_r;
        full_r    <= full_r;
      end
    end
  end

  // Row and column drive for the current scan position, before registering.
  always_comb begin
    row_bits_s  = frame_row(display_r, row_r);
    lit_s       = is_on_s && !bus.blank;
    row_drive_s = ROWS_OFF;
    col_drive_s = COLS_OFF;
    if (lit_s) begin
      row_drive_s = ROWS'(1'b1) << row_r;
      if (COL_ACTIVE_LOW) begin
        col_drive_s = ~row_bits_s;
      end else begin
        col_drive_s = row_bits_s;
      end
    end else begin
      row_drive_s = ROWS_OFF;
      col_drive_s = COLS_OFF;
    end
  end

  // Registered matrix outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rows_r       <= ROWS_OFF;
      cols_r       <= COLS_OFF;
      row_index_r  <= ROW_ZERO;
      frame_sync_r <= 1'b0;
    end else begin
      rows_r       <= row_drive_s;
      cols_r       <= col_drive_s;
      row_index_r  <= row_r;
      frame_sync_r <= sync_s;
    end
  end

  assign bus.frame_ready = ready_s;
  assign bus.rows        = rows_r;
  assign bus.cols        = cols_r;
  assign bus.row_index   = row_index_r;
  assign bus.frame_sync  = frame_sync_r;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner with DWELL=4, BLANK=1 (30-cycle frame).
module tb_led_matrix_scanner;
  import sga_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  led_matrix_scanner_if ifc ();

  led_matrix_scanner #(
    .ROWS           (6),
    .COLS           (6),
    .DWELL_CYCLES   (4),
    .BLANK_CYCLES   (1),
    .COL_ACTIVE_LOW (1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0] rows;
    logic [5:0] cols;
    logic [2:0] row_index;
    logic       sync;
  } exp_t;

  typedef struct {
    logic [35:0]     frame;
    logic [5:0][5:0] rc;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  int          checks   = 0;
  int          failures = 0;
  int          tcyc     = 0;
  logic        m_full;
  logic [35:0] m_pend;
  logic [35:0] m_disp;
  logic        last_acc;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=%h required=%h", name, tcyc, act, exp);
    end
  endtask

  // One clock: check ready, predict next outputs, drive inputs, compare.
  task automatic step(input logic v, input logic [35:0] f, input logic b);
    exp_t        e;
    int          p;
    int          row;
    logic        exp_ready;
    logic        bnd;
    logic [5:0]  dr;
    p         = tcyc % 30;
    row       = p / 5;
    bnd       = (p == 29);
    exp_ready = !m_full || bnd;
    chk("frame_ready", ifc.frame_ready, exp_ready);
    dr          = m_disp[row*6 +: 6];
    e.row_index = row[2:0];
    e.sync      = (p == 0);
    if ((p % 5) != 0 && !b) begin
      e.rows = 6'b000001 << row;
      e.cols = ~dr;
    end else begin
      e.rows = 6'b000000;
      e.cols = 6'b111111;
    end
    sb.push_back(e);
    last_acc = v && exp_ready;
    if (bnd && m_full) begin
      m_disp = m_pend;
      m_full = 1'b0;
    end
    if (last_acc) begin
      m_pend = f;
      m_full = 1'b1;
    end
    ifc.frame_valid = v;
    ifc.frame       = f;
    ifc.blank       = b;
    @(negedge clock);
    tcyc++;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 36'd0, 36'd1);
    end else begin
      e = sb.pop_front();
      chk("rows", ifc.rows, e.rows);
      chk("cols", ifc.cols, e.cols);
      chk("row_index", ifc.row_index, e.row_index);
      chk("frame_sync", ifc.frame_sync, e.sync);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 36'd0, 1'b0);
  endtask

  // Assert reset mid-cycle, check the asynchronous reset values, then release.
  task automatic do_reset();
    @(negedge clock);
    #2;
    reset = 1'b1;
    ifc.frame_valid = 1'b0;
    ifc.frame       = 36'd0;
    ifc.blank       = 1'b0;
    #1;
    chk("rst_rows", ifc.rows, 6'b000000);
    chk("rst_cols", ifc.cols, 6'b111111);
    chk("rst_row_index", ifc.row_index, 3'd0);
    chk("rst_frame_sync", ifc.frame_sync, 1'b0);
    chk("rst_frame_ready", ifc.frame_ready, 1'b1);
    sb.delete();
    m_full = 1'b0;
    m_pend = 36'd0;
    m_disp = 36'd0;
    @(negedge clock);
    reset = 1'b0;
    tcyc  = 0;
  endtask

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    while ((tcyc % 30) != ph && n < 40) begin
      step(1'b0, 36'd0, 1'b0);
      n++;
    end
    chk("wait_phase_timeout", ((tcyc % 30) == ph) ? 36'd1 : 36'd0, 36'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0d actual=timeout required=finish", tcyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int bnd_t;
    int n;
    vecs[0].frame = 36'h000000001;
    vecs[0].rc    = {6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3E};
    vecs[1].frame = 36'hFFFFFFFFF;
    vecs[1].rc    = {6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    vecs[2].frame = 36'h00000003F;
    vecs[2].rc    = {6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h00};
    vecs[3].frame = 36'hFC0000000;
    vecs[3].rc    = {6'h00, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
    vecs[4].frame = 36'h000000000;
    vecs[4].rc    = {6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
    vecs[5].frame = 36'h820820820;
    vecs[5].rc    = {6'h1F, 6'h1F, 6'h1F, 6'h1F, 6'h1F, 6'h1F};

    ifc.frame_valid = 1'b0;
    ifc.frame       = 36'd0;
    ifc.blank       = 1'b0;
    last_acc        = 1'b0;

    // Reset and idle: two full frames of dark columns and sync pulses.
    do_reset();
    idle(61);

    // Table-driven single frames, accepted mid-frame.
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (m_full && n < 100) begin
        step(1'b0, 36'd0, 1'b0);
        n++;
      end
      wait_phase(10);
      step(1'b1, vecs[i].frame, 1'b0);
      bnd_t = ((tcyc + 29) / 30) * 30;
      for (int r = 0; r < 6; r++) begin
        while (tcyc < bnd_t + 5 * r + 2) step(1'b0, 36'd0, 1'b0);
        chk("tbl_rows", ifc.rows, 6'b000001 << r);
        chk("tbl_cols", ifc.cols, vecs[i].rc[r]);
      end
    end

    // Back-to-back frames with valid held high.
    idle(30);
    wait_phase(5);
    step(1'b1, 36'h00000003F, 1'b0);
    n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 40) begin
      step(1'b1, 36'hFC0000000, 1'b0);
      n++;
    end
    chk("b2b_accept_timeout", last_acc ? 36'd1 : 36'd0, 36'd1);
    idle(65);

    // Blank held for 12 cycles mid-scan.
    wait_phase(7);
    for (int i = 0; i < 12; i++) step(1'b0, 36'd0, 1'b1);
    idle(25);

    // Reset during row 3 with a frame pending.
    wait_phase(12);
    step(1'b1, 36'h123456789, 1'b0);
    wait_phase(16);
    do_reset();
    idle(35);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
